// File: rtl/fixed_point_vector_alu.sv
// fixed_point_vector_alu: two-stage, multi-lane signed fixed-point
// add / subtract / accumulate / load unit with valid/ready handshakes.
// Build option: define SATURATE_EN to clamp overflowing lanes to +max/-max;
// without it, overflowing lanes wrap (two's complement).
module fixed_point_vector_alu #(
  parameter int INT_W  = 8,
  parameter int FRAC_W = 8,
  parameter int LANES  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [LANES*(INT_W+FRAC_W)-1:0] A,
  input  logic [LANES*(INT_W+FRAC_W)-1:0] B,
  input  logic [1:0]                      op,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [LANES*(INT_W+FRAC_W)-1:0] Out,
  output logic [LANES-1:0]                N,
  output logic [LANES-1:0]                V,
  output logic [LANES-1:0]                Z,
  output logic                            v_sticky,
  input  logic                            clr_sticky
);

  localparam int DW = INT_W + FRAC_W;
  localparam int VW = LANES * DW;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  // Stage 1 registers
  logic          s1_valid;
  op_e           s1_op;
  logic [VW-1:0] s1_a;
  logic [VW-1:0] s1_b;
  logic          s1_cin;

  // Per-lane accumulators, packed like the operand buses
  logic [VW-1:0] acc;

  // Stage 2 combinational results
  logic [VW-1:0]    res;
  logic [LANES-1:0] res_n;
  logic [LANES-1:0] res_v;
  logic [LANES-1:0] res_z;
  logic [DW-1:0]    x;
  logic [DW-1:0]    y;
  logic [DW:0]      sum;
  logic [DW-1:0]    lane_out;
  logic             ovf;

  logic s2_adv;
  logic s1_adv;
  logic s2_load;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign s2_load  = s2_adv && s1_valid;

  // Stage 1: capture operands; subtraction stored as ~B with carry-in 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_ADD;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cin   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op  <= op_e'(op);
        s1_a   <= A;
        s1_b   <= (op == OP_SUB) ? ~B : B;
        s1_cin <= (op == OP_SUB);
      end
    end
  end

  // Per-lane DW+1-bit sum, overflow detect, optional clamp and flags
  always_comb begin
    res      = '0;
    res_n    = '0;
    res_v    = '0;
    res_z    = '0;
    x        = '0;
    y        = '0;
    sum      = '0;
    lane_out = '0;
    ovf      = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      case (s1_op)
        OP_ACC: begin
          x = acc[i*DW +: DW];
          y = s1_a[i*DW +: DW];
        end
        // Load is computed as 0 + A so it shares the adder and cannot overflow
        OP_LOAD: begin
          x = '0;
          y = s1_a[i*DW +: DW];
        end
        default: begin
          x = s1_a[i*DW +: DW];
          y = s1_b[i*DW +: DW];
        end
      endcase
      sum = {x[DW-1], x} + {y[DW-1], y} + {{DW{1'b0}}, s1_cin};
      ovf = sum[DW] ^ sum[DW-1];
`ifdef SATURATE_EN
      if (ovf) begin
        lane_out = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end else begin
        lane_out = sum[DW-1:0];
      end
`else
      lane_out = sum[DW-1:0];
`endif
      res[i*DW +: DW] = lane_out;
      res_v[i]        = ovf;
      res_n[i]        = lane_out[DW-1];
      res_z[i]        = (lane_out == '0);
    end
  end

  // Stage 2: result registers and accumulator update on the S1->S2 transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Out       <= '0;
      N         <= '0;
      V         <= '0;
      Z         <= '0;
      acc       <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        Out <= res;
        N   <= res_n;
        V   <= res_v;
        Z   <= res_z;
        if (s1_op == OP_ACC || s1_op == OP_LOAD) begin
          acc <= res;
        end
      end
    end
  end

  // Sticky overflow: a new V event takes priority over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_sticky <= 1'b0;
    end else if (s2_load && (|res_v)) begin
      v_sticky <= 1'b1;
    end else if (clr_sticky) begin
      v_sticky <= 1'b0;
    end
  end

endmodule
